hazard_ctrl: RTL

Pipeline sequencing controller for the five-stage P7 core. Decides every cycle whether the F/D/E/M/W pipeline registers advance, hold, bubble or take the exception flush. It combines three sources: the Tuse/Tnew data-hazard check, a cycle-accurate mult/div busy timer, and the exception request raised at M. It drives the enable, flush and `req` inputs of every stage register. The shadow-register side of exceptions belongs to CP0; this block only sequences the pipeline.

---
 rtl/hazard_ctrl_pkg.sv | 32 +++
 rtl/hazard_ctrl_md_timer.sv | 52 +++++
 rtl/hazard_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and constants for the P7 pipeline sequencing controller.
// The source hazard rule is kept here so that the rs and rt checks share one definition.
package hazard_ctrl_pkg;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   localparam logic [7:0] TUSE_NONE        = 8'hFF;
   localparam int         MULT_CYCLES_DEF  = 5;
   localparam int         DIV_CYCLES_DEF   = 10;

   // A source operand stalls when a producer in E or M cannot forward it in time.
   function automatic logic src_hazard(
      input logic [4:0] src,
      input logic [7:0] tuse,
      input logic       wen_e,
      input logic [4:0] wr_e,
      input logic [7:0] tnew_e,
      input logic       wen_m,
      input logic [4:0] wr_m,
      input logic [7:0] tnew_m
   );
      logic hit_e;
      logic hit_m;
      hit_e = wen_e && (wr_e == src) && (tnew_e > tuse);
      hit_m = wen_m && (wr_m == src) && (tnew_m > tuse);
      return (src != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
   endfunction

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// Mult/div occupancy timer: counts down the busy cycles of an accepted operation.
// An accepted op always runs to completion; only reset can cut it short.
module md_timer
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      start_ok,
   input  logic      is_div,
   output logic      busy,
   output md_state_t state
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= MD_IDLE;
         count <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (start_ok) begin
                  count <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  state <= MD_BUSY;
                  busy  <= 1'b1;
               end
            end
            MD_BUSY: begin
               if (count == CNT_W'(1)) begin
                  count <= '0;
                  state <= MD_IDLE;
                  busy  <= 1'b0;
               end else begin
                  count <= count - 1'b1;
               end
            end
            default: begin
               state <= MD_IDLE;
               count <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: combines Tuse/Tnew data hazards, the mult/div
// busy timer and the M-stage exception request into stage enables and flushes.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs_D,
   input  logic [4:0]  rt_D,
   input  logic [7:0]  TUseRs_D,
   input  logic [7:0]  TUseRt_D,
   input  logic [4:0]  WR_E,
   input  logic [4:0]  WR_M,
   input  logic        RegWrite_E,
   input  logic        RegWrite_M,
   input  logic [7:0]  TNew_E,
   input  logic [7:0]  TNew_M,
   input  logic        MdStart_E,
   input  logic        MdIsDiv_E,
   input  logic        MdUse_D,
   input  logic        ExcReq_M,
   output logic        EnF,
   output logic        EnD,
   output logic        FlushE,
   output logic        req,
   output logic        MdStartOk_E,
   output logic        MdBusy,
   output logic [31:0] StallCnt
);

   md_state_t md_state;
   logic      hazard_rs;
   logic      hazard_rt;
   logic      hazard_md;
   logic      stall;

   // MdStart_E acts as valid and the timer being idle (with no exception pending)
   // as ready; MdStartOk_E is their product, and the op is taken on that edge.
   assign MdStartOk_E = MdStart_E & ~ExcReq_M & ~(md_state == MD_BUSY);

   md_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_timer (
      .clk      (clk),
      .reset    (reset),
      .start_ok (MdStartOk_E),
      .is_div   (MdIsDiv_E),
      .busy     (MdBusy),
      .state    (md_state)
   );

   assign hazard_rs = src_hazard(rs_D, TUseRs_D, RegWrite_E, WR_E, TNew_E,
                                 RegWrite_M, WR_M, TNew_M);
   assign hazard_rt = src_hazard(rt_D, TUseRt_D, RegWrite_E, WR_E, TNew_E,
                                 RegWrite_M, WR_M, TNew_M);
   assign hazard_md = MdUse_D & (MdBusy | MdStart_E);

   // An exception overrides any stall: the stage registers clear themselves on req.
   assign stall  = (hazard_rs | hazard_rt | hazard_md) & ~ExcReq_M;
   assign req    = ExcReq_M;
   assign EnF    = ~stall;
   assign EnD    = ~stall;
   assign FlushE = stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         StallCnt <= '0;
      end else if (stall) begin
         StallCnt <= StallCnt + 32'd1;
      end
   end

endmodule
